// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline stall/flush sequencer and its neighbours.
// master drives hazard/branch/memory status; slave (pipeline_ctrl) drives stage controls.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             load_use_hz;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ack;
    logic             err_clr;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output load_use_hz, branch_taken, dmem_req, dmem_ack, err_clr,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
               memwb_bubble, mem_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  load_use_hz, branch_taken, dmem_req, dmem_ack, err_clr,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we,
               memwb_bubble, mem_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: freezes on slow data-memory
// accesses, bubbles on load-use hazards, flushes on taken branches, and keeps perf counters.
module pipeline_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input logic           clk,
    input logic           rst_n,
    pipeline_ctrl_if.slave bus
);
    localparam int                WCNT_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        RUN,
        MEM_WAIT
    } state_t;

    state_t            state_q;
    logic [WCNT_W-1:0] wcnt_q;
    logic              memErr_q, memErr_d;
    logic [CNT_W-1:0]  stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0]  flushCnt_q, flushCnt_d;
    logic              freeze, timeout, stallEvt, flushEvt;

    // A release from MEM_WAIT (ack or timeout) is an ordinary advance cycle.
    always_comb begin
        freeze  = 1'b0;
        timeout = 1'b0;
        if (state_q == RUN) begin
            freeze = bus.dmem_req && !bus.dmem_ack;
        end else begin
            freeze  = !bus.dmem_ack && (wcnt_q != WCNT_LAST);
            timeout = !bus.dmem_ack && (wcnt_q == WCNT_LAST);
        end
    end

    always_comb begin
        bus.pc_we        = rst_n;
        bus.ifid_we      = rst_n;
        bus.idex_we      = rst_n;
        bus.exmem_we     = rst_n;
        bus.ifid_flush   = 1'b0;
        bus.idex_flush   = 1'b0;
        bus.memwb_bubble = 1'b0;
        stallEvt         = 1'b0;
        flushEvt         = 1'b0;
        if (rst_n) begin
            if (freeze) begin
                bus.pc_we        = 1'b0;
                bus.ifid_we      = 1'b0;
                bus.idex_we      = 1'b0;
                bus.exmem_we     = 1'b0;
                bus.memwb_bubble = 1'b1;
                stallEvt         = 1'b1;
            end else if (bus.branch_taken) begin
                // The load-use victim is on the wrong path, so the hazard is moot.
                bus.ifid_flush = 1'b1;
                bus.idex_flush = 1'b1;
                flushEvt       = 1'b1;
            end else if (bus.load_use_hz) begin
                bus.pc_we      = 1'b0;
                bus.ifid_we    = 1'b0;
                bus.idex_flush = 1'b1;
                stallEvt       = 1'b1;
            end
        end
    end

    always_comb begin
        stallCnt_d = (stallEvt && stallCnt_q != CNT_MAX) ? stallCnt_q + CNT_W'(1) : stallCnt_q;
        flushCnt_d = (flushEvt && flushCnt_q != CNT_MAX) ? flushCnt_q + CNT_W'(1) : flushCnt_q;
        memErr_d   = timeout ? 1'b1 : (bus.err_clr ? 1'b0 : memErr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            wcnt_q     <= '0;
            memErr_q   <= 1'b0;
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            memErr_q   <= memErr_d;
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
            case (state_q)
                RUN: begin
                    if (freeze) begin
                        state_q <= MEM_WAIT;
                        wcnt_q  <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (freeze) begin
                        wcnt_q <= wcnt_q + WCNT_W'(1);
                    end else begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign bus.mem_err   = memErr_q;
    assign bus.stall_cnt = stallCnt_q;
    assign bus.flush_cnt = flushCnt_q;
endmodule
